// File: rtl/ss_pkg.sv
// ss_pkg: seven-segment glyph constants and display polarity constants
package ss_pkg;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [3:0] ANODES_OFF = 4'hF;
  localparam logic [7:0] SEGS_OFF   = 8'hFF;
endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: BCD digit to active-high {g,f,e,d,c,b,a}; non-decimal codes show a dash
module bcd_to_seg
  import ss_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/ss_scan_driver.sv
// ss_scan_driver: multiplexed 4-digit seven-segment driver with PWM, dead time and frame latching
module ss_scan_driver
  import ss_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int PWM_BITS = 4,
  parameter int DEAD_CYC = 16
) (
  input  logic                Clk_100M,
  input  logic                Reset,
  input  logic [3:0]          Digit3,
  input  logic [3:0]          Digit2,
  input  logic [3:0]          Digit1,
  input  logic [3:0]          Digit0,
  input  logic [3:0]          DP,
  input  logic                Blank_Leading,
  input  logic [PWM_BITS-1:0] Brightness,
  output logic [3:0]          SegmentDrivers,
  output logic [7:0]          SevenSegment,
  output logic                Frame_Strobe
);
  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] DEAD = PW'(DEAD_CYC);
  logic [PW-1:0]       pre_q, pre_d;
  logic [1:0]          idx_q, idx_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [15:0]         sh_dig_q, sh_dig_d;
  logic [3:0]          sh_dp_q, sh_dp_d;
  logic                sh_bl_q, sh_bl_d;
  logic [3:0]          an_q, an_d;
  logic [7:0]          seg_q, seg_d;
  logic                fs_q, fs_d;
  logic                slot_tick, blank, lit;
  logic [3:0]          cur;
  logic [6:0]          pat;
  assign cur = sh_dig_q[{idx_q, 2'b00} +: 4];
  bcd_to_seg u_dec (.bcd(cur), .seg(pat));
  // Segment data follows the slot from its first cycle; the dead window keeps anodes off while it settles.
  always_comb begin
    slot_tick = pre_q == LAST;
    pre_d     = slot_tick ? '0 : pre_q + PW'(1);
    idx_d     = slot_tick ? idx_q + 2'd1 : idx_q;
    pwm_d     = pwm_q + PWM_BITS'(1);
    sh_dig_d  = (slot_tick && idx_q == 2'd3) ? {Digit3, Digit2, Digit1, Digit0} : sh_dig_q;
    sh_dp_d   = (slot_tick && idx_q == 2'd3) ? DP : sh_dp_q;
    sh_bl_d   = (slot_tick && idx_q == 2'd3) ? Blank_Leading : sh_bl_q;
    blank     = sh_bl_q && idx_q == 2'd3 && cur == 4'd0;
    lit       = !blank && pre_q >= DEAD && pwm_q < Brightness;
    an_d      = lit ? ~(4'b0001 << idx_q) : ANODES_OFF;
    seg_d     = blank ? SEGS_OFF : {~sh_dp_q[idx_q], ~pat};
    fs_d      = idx_q == 2'd0 && pre_q == '0;
  end
  always_ff @(posedge Clk_100M or posedge Reset) begin
    if (Reset) begin
      pre_q    <= '0;
      idx_q    <= '0;
      pwm_q    <= '0;
      sh_dig_q <= '0;
      sh_dp_q  <= '0;
      sh_bl_q  <= 1'b0;
      an_q     <= ANODES_OFF;
      seg_q    <= SEGS_OFF;
      fs_q     <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      pwm_q    <= pwm_d;
      sh_dig_q <= sh_dig_d;
      sh_dp_q  <= sh_dp_d;
      sh_bl_q  <= sh_bl_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      fs_q     <= fs_d;
    end
  end
  assign SegmentDrivers = an_q;
  assign SevenSegment   = seg_q;
  assign Frame_Strobe   = fs_q;
endmodule

// File: tb/tb_ss_scan_driver.sv
// tb_ss_scan_driver: cycle-count model of the scan driver checked every cycle plus directed literal checks
module tb_ss_scan_driver;
  logic       clk = 1'b0;
  logic       Reset;
  logic [3:0] Digit3, Digit2, Digit1, Digit0, DP;
  logic       Blank_Leading;
  logic [1:0] Brightness;
  logic [3:0] SegmentDrivers;
  logic [7:0] SevenSegment;
  logic       Frame_Strobe;
  int vectors = 0;
  int errs = 0;
  bit chk_en = 1'b0;
  int c;
  logic [15:0] m_dig;
  logic [3:0]  m_dp;
  logic        m_bl;
  logic [12:0] exp_v;

  ss_scan_driver #(.CLK_HZ(1000), .SCAN_HZ(100), .PWM_BITS(2), .DEAD_CYC(2)) dut (
    .Clk_100M(clk), .Reset(Reset), .Digit3(Digit3), .Digit2(Digit2), .Digit1(Digit1),
    .Digit0(Digit0), .DP(DP), .Blank_Leading(Blank_Leading), .Brightness(Brightness),
    .SegmentDrivers(SegmentDrivers), .SevenSegment(SevenSegment), .Frame_Strobe(Frame_Strobe)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return 8'hBF;
    endcase
  endfunction

  // Output after an edge reflects cycle number n since reset: slot = n/10, pwm phase = n%4.
  function automatic logic [12:0] model(input int n, input logic [15:0] dig, input logic [3:0] dp,
                                        input logic bl, input logic [1:0] br);
    int pre = n % 10;
    int idx = (n / 10) % 4;
    logic [3:0] d = dig[idx*4 +: 4];
    logic blank = bl && idx == 3 && d == 4'd0;
    logic [3:0] an = 4'hF;
    logic [7:0] seg = glyph(d);
    seg[7] = ~dp[idx];
    if (blank) seg = 8'hFF;
    if (!blank && pre >= 2 && (n % 4) < int'(br)) an[idx] = 1'b0;
    return {n % 40 == 0, an, seg};
  endfunction

  always @(posedge clk or posedge Reset) begin
    if (Reset) begin
      c <= 0;
      m_dig <= '0;
      m_dp <= '0;
      m_bl <= 1'b0;
      exp_v <= {1'b0, 4'hF, 8'hFF};
    end else begin
      exp_v <= model(c, m_dig, m_dp, m_bl, Brightness);
      if (c % 40 == 39) begin
        m_dig <= {Digit3, Digit2, Digit1, Digit0};
        m_dp <= DP;
        m_bl <= Blank_Leading;
      end
      c <= c + 1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("an", {28'd0, SegmentDrivers}, {28'd0, exp_v[11:8]});
      check("seg", {24'd0, SevenSegment}, {24'd0, exp_v[7:0]});
      check("fs", {31'd0, Frame_Strobe}, {31'd0, exp_v[12]});
      check("one_anode", ($countones(~SegmentDrivers) <= 1) ? 32'd1 : 32'd0, 32'd1);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic to_c(input int t);
    if (t > c) step(t - c);
  endtask

  initial begin
    int gap, k, lows;
    Reset = 1'b1;
    {Digit3, Digit2, Digit1, Digit0} = 16'h1234;
    DP = 4'b0000;
    Blank_Leading = 1'b0;
    Brightness = 2'd3;
    step(3);
    check("rst_an", {28'd0, SegmentDrivers}, 32'hF);
    check("rst_seg", {24'd0, SevenSegment}, 32'hFF);
    check("rst_fs", {31'd0, Frame_Strobe}, 32'd0);
    @(negedge clk);
    Reset = 1'b0;
    chk_en = 1'b1;
    step(1);
    check("fs_first", {31'd0, Frame_Strobe}, 32'd1);
    check("frame0_zero", {24'd0, SevenSegment}, 32'hC0);
    gap = -1;
    k = 0;
    while (gap < 0 && k < 60) begin
      step(1);
      k++;
      if (Frame_Strobe) gap = k;
    end
    check("fs_period", gap, 32'd40);
    check("f1_d0_is4", {24'd0, SevenSegment}, 32'h99);
    to_c(43);
    check("f1_d0_anode", {28'd0, SegmentDrivers}, 32'hE);
    to_c(44);
    check("pwm_off_phase", {28'd0, SegmentDrivers}, 32'hF);
    to_c(51);
    check("f1_d1_is3", {24'd0, SevenSegment}, 32'hB0);
    to_c(71);
    check("f1_d3_is1", {24'd0, SevenSegment}, 32'hF9);
    Digit0 = 4'd5;
    to_c(81);
    check("f2_d0_is5", {24'd0, SevenSegment}, 32'h92);
    to_c(105);
    Digit0 = 4'd6;
    to_c(121);
    check("f3_d0_is6", {24'd0, SevenSegment}, 32'h82);
    Digit3 = 4'd0;
    Blank_Leading = 1'b1;
    to_c(191);
    check("blank_seg", {24'd0, SevenSegment}, 32'hFF);
    to_c(195);
    check("blank_an", {28'd0, SegmentDrivers}, 32'hF);
    Blank_Leading = 1'b0;
    Digit1 = 4'hC;
    DP = 4'b0100;
    to_c(201);
    check("f5_d0", {24'd0, SevenSegment}, 32'h82);
    to_c(211);
    check("dash", {24'd0, SevenSegment}, 32'hBF);
    to_c(221);
    check("dp_slot2", {24'd0, SevenSegment}, 32'h24);
    to_c(231);
    check("lead_zero", {24'd0, SevenSegment}, 32'hC0);
    to_c(240);
    Brightness = 2'd0;
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (SegmentDrivers != 4'hF) lows++;
    end
    check("dark_lows", lows, 32'd0);
    Brightness = 2'd1;
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (SegmentDrivers != 4'hF) lows++;
    end
    check("dim_lows", lows, 32'd8);
    Brightness = 2'd3;
    to_c(345);
    check("pre_rst_an", {28'd0, SegmentDrivers}, 32'hB);
    Reset = 1'b1;
    #1;
    check("async_an", {28'd0, SegmentDrivers}, 32'hF);
    check("async_seg", {24'd0, SevenSegment}, 32'hFF);
    check("async_fs", {31'd0, Frame_Strobe}, 32'd0);
    step(2);
    @(negedge clk);
    Reset = 1'b0;
    step(1);
    check("rerst_fs", {31'd0, Frame_Strobe}, 32'd1);
    check("rerst_seg", {24'd0, SevenSegment}, 32'hC0);
    step(80);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
